// File: rtl/ram_pkg.sv
// Shared types and helpers for the pipelined data RAM: access sizes, response stage payload,
// and byte-lane enable / alignment mask generation.
package ram_pkg;

   localparam int unsigned RAM_MAX_DW = 64;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } mem_size_e;

   // rdata is sized for the widest legal bus; narrower builds use the low bits only
   typedef struct packed {
      logic                  valid;
      logic [RAM_MAX_DW-1:0] rdata;
      logic                  write;
      logic                  err;
   } ram_stage_t;

   // Offset bits that must be zero for a naturally aligned access of this size
   function automatic logic [2:0] size_low_mask(input mem_size_e size);
      logic [2:0] mask;
      case (size)
         SZ_B:    mask = 3'd0;
         SZ_H:    mask = 3'd1;
         SZ_W:    mask = 3'd3;
         default: mask = 3'd7;
      endcase
      return mask;
   endfunction

   function automatic logic [7:0] byte_en(input mem_size_e size, input logic [2:0] offset);
      logic [7:0] lanes;
      case (size)
         SZ_B:    lanes = 8'h01;
         SZ_H:    lanes = 8'h03;
         SZ_W:    lanes = 8'h0F;
         default: lanes = 8'hFF;
      endcase
      return lanes << offset;
   endfunction

endpackage

// File: rtl/ram_load_align.sv
// Load data alignment: shifts the raw memory word down by the byte offset, keeps the
// access-size bytes and sign- or zero-extends to the bus width. Purely combinational.
module ram_load_align
   import ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] raw_i,
   input  logic [2:0]            offset_i,
   input  mem_size_e             size_i,
   input  logic                  unsigned_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] keep;
   logic                  sign;

   assign shifted = raw_i >> {offset_i, 3'b000};

   // Keep mask and sign bit position per access size
   always_comb begin
      keep = '1;
      sign = shifted[DATA_WIDTH-1];
      case (size_i)
         SZ_B: begin
            keep = DATA_WIDTH'(8'hFF);
            sign = shifted[7];
         end
         SZ_H: begin
            keep = DATA_WIDTH'(16'hFFFF);
            sign = shifted[15];
         end
         SZ_W: begin
            keep = DATA_WIDTH'(32'hFFFF_FFFF);
            sign = shifted[31];
         end
         default: ;
      endcase
   end

   assign data_o = (shifted & keep) | ((sign && !unsigned_i) ? ~keep : '0);

endmodule

// File: rtl/ram_pipelined.sv
// Byte-addressable data RAM with valid/ready handshakes and a READ_LATENCY-deep response pipeline.
// Define RAM_MISALIGN_TRAP_EN to fault misaligned accesses; otherwise they are aligned down silently.
module ram_pipelined
   import ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_write,
   output logic                  resp_err
);

   localparam int unsigned NB    = DATA_WIDTH / 8;
   localparam int unsigned OFF_W = $clog2(NB);
   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned LAST  = READ_LATENCY - 1;

   if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_chk_dw
      $error("ram_pipelined: DATA_WIDTH must be 32 or 64");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_chk_lat
      $error("ram_pipelined: READ_LATENCY must be in 1..4");
   end
   if ((1 << IDX_W) != DEPTH_WORDS) begin : g_chk_depth
      $error("ram_pipelined: DEPTH_WORDS must be a power of two");
   end

   logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
   ram_stage_t            stage_q [READ_LATENCY];
   ram_stage_t            stage0_d;

   mem_size_e             size;
   logic [2:0]            off3;
   logic [2:0]            low_mask;
   logic [2:0]            off_eff;
   logic [IDX_W-1:0]      idx;
   logic [NB-1:0]         be;
   logic [DATA_WIDTH-1:0] wdata_sh;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  range_err;
   logic                  size_err;
   logic                  misalign_err;
   logic                  fault;
   logic                  advance;
   logic                  accept;

   assign size     = mem_size_e'(req_size);
   assign off3     = 3'(req_addr[OFF_W-1:0]);
   assign low_mask = size_low_mask(size);
   assign idx      = req_addr[OFF_W +: IDX_W];

`ifdef RAM_MISALIGN_TRAP_EN
   assign misalign_err = (off3 & low_mask) != 3'd0;
   assign off_eff      = off3;
`else
   assign misalign_err = 1'b0;
   assign off_eff      = off3 & ~low_mask;
`endif

   // Depth is a power of two, so any set bit above the word index is out of range
   if (ADDR_WIDTH > OFF_W + IDX_W) begin : g_range
      assign range_err = |req_addr[ADDR_WIDTH-1:OFF_W+IDX_W];
   end else begin : g_no_range
      assign range_err = 1'b0;
   end

   assign size_err = (size == SZ_D) && (DATA_WIDTH != 64);
   assign fault    = range_err || size_err || misalign_err;

   assign advance   = !stage_q[LAST].valid || resp_ready;
   assign accept    = req_valid && advance;
   assign req_ready = advance;

   assign be       = NB'(byte_en(size, off_eff));
   assign wdata_sh = req_wdata << {off_eff, 3'b000};

   // Array is not reset; writes only happen out of reset on an accepted, fault-free store
   always_ff @(posedge clk) begin
      if (rst && accept && req_write && !fault) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
         end
      end
   end

   assign rd_word = mem_q[idx];

   ram_load_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_align (
      .raw_i      (rd_word),
      .offset_i   (off_eff),
      .size_i     (size),
      .unsigned_i (req_unsigned),
      .data_o     (ld_data)
   );

   // Stage 0 payload; a non-accepting advance loads a bubble
   always_comb begin
      stage0_d       = '0;
      stage0_d.valid = accept;
      stage0_d.write = accept && req_write;
      stage0_d.err   = accept && fault;
      if (accept && !req_write && !fault) stage0_d.rdata = RAM_MAX_DW'(ld_data);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < READ_LATENCY; s++) stage_q[s] <= '0;
      end else if (advance) begin
         stage_q[0] <= stage0_d;
         for (int s = 1; s < READ_LATENCY; s++) stage_q[s] <= stage_q[s-1];
      end
   end

   assign resp_valid = stage_q[LAST].valid;
   assign resp_write = stage_q[LAST].write;
   assign resp_err   = stage_q[LAST].err;
   assign resp_rdata = stage_q[LAST].rdata[DATA_WIDTH-1:0];

   if (DATA_WIDTH < RAM_MAX_DW) begin : g_rdata_hi
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^stage_q[LAST].rdata[RAM_MAX_DW-1:DATA_WIDTH];
   end

endmodule

// File: tb/tb_ram_pipelined.sv
// Scoreboard bench for ram_pipelined: a byte-array reference model predicts each response
// at acceptance; an independent monitor pops and compares every consumed response.
module tb_ram_pipelined;

   localparam int unsigned DW        = 32;
   localparam int unsigned AW        = 32;
   localparam int unsigned DEPTH     = 1024;
   localparam int unsigned RL        = 2;
   localparam int unsigned MEM_BYTES = DEPTH * DW / 8;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_rdata;
   logic          resp_write;
   logic          resp_err;

   typedef struct {
      logic        wr;
      logic        err;
      logic [31:0] rdata;
      bit          lat_chk;
      int          acc_edge;
      bit          has_const;
      logic [31:0] c_rdata;
      logic        c_err;
      string       name;
   } exp_t;

   exp_t        expq[$];
   logic [7:0]  mem_b [MEM_BYTES];
   logic [31:0] pre_word [16];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   bit          acc_flag = 0;
   bit          rr_force_low = 0;
   bit          rr_random = 0;
   bit          cur_lat, cur_hc, cur_cerr;
   logic [31:0] cur_crd;
   string       cur_name;

   ram_pipelined #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .DEPTH_WORDS  (DEPTH),
      .READ_LATENCY (RL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_write   (resp_write),
      .resp_err     (resp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
      end
   endfunction

   // Little-endian byte memory; loads assemble bytes then extend from the top bit of the access
   function automatic exp_t model(input bit wr, input logic [1:0] sz, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wd);
      exp_t            e;
      int              nb;
      longint unsigned a;
      longint unsigned v;
      nb      = 1 << sz;
      a       = longint'(addr);
      e.wr    = wr;
      e.err   = 1'b0;
      e.rdata = 32'd0;
      if (a >= MEM_BYTES || sz == 2'd3) e.err = 1'b1;
`ifdef RAM_MISALIGN_TRAP_EN
      if (a % nb != 0) e.err = 1'b1;
`else
      a = a - (a % nb);
`endif
      if (!e.err) begin
         if (wr) begin
            for (int i = 0; i < nb; i++) mem_b[a+i] = wd[8*i +: 8];
         end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (longint'(mem_b[a+i]) << (8*i));
            if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
            e.rdata = v[31:0];
         end
      end
      return e;
   endfunction

   // Response consumer
   initial begin
      resp_ready = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         resp_ready = rr_force_low ? 1'b0 : (rr_random ? ($urandom_range(3) != 0) : 1'b1);
      end
   end

   // Acceptance: predict and enqueue
   initial forever begin
      @(negedge clk);
      #2;
      if (rst && req_valid && req_ready) begin
         exp_t e;
         e = model(req_write, req_size, req_unsigned, req_addr, req_wdata);
         e.lat_chk   = cur_lat;
         e.acc_edge  = cyc + 1;
         e.has_const = cur_hc;
         e.c_rdata   = cur_crd;
         e.c_err     = cur_cerr;
         e.name      = cur_name;
         expq.push_back(e);
         acc_flag = 1'b1;
      end else begin
         acc_flag = 1'b0;
      end
   end

   // Monitor: compare every consumed response in order
   initial forever begin
      @(negedge clk);
      #3;
      if (rst && resp_valid && resp_ready) begin
         exp_t e;
         if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_resp: got a response, expected none (t=%0t)", $time);
         end else begin
            e = expq.pop_front();
            chk({e.name, "_write"}, 64'(resp_write), 64'(e.wr));
            chk({e.name, "_err"}, 64'(resp_err), 64'(e.err));
            chk({e.name, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
            if (e.has_const) begin
               chk({e.name, "_const_rdata"}, 64'(resp_rdata), 64'(e.c_rdata));
               chk({e.name, "_const_err"}, 64'(resp_err), 64'(e.c_err));
            end
            if (e.lat_chk) chk({e.name, "_latency"}, 64'(cyc - e.acc_edge), 64'(RL - 1));
         end
      end
   end

   task automatic issue(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                        input logic [31:0] wd, input string nm = "rand", input bit hc = 1'b0,
                        input logic [31:0] crd = 32'd0, input bit cerr = 1'b0, input bit lat = 1'b0);
      int n;
      @(negedge clk);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      cur_name     = nm;
      cur_hc       = hc;
      cur_crd      = crd;
      cur_cerr     = cerr;
      cur_lat      = lat;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!acc_flag && n < 200);
      if (!acc_flag) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout %s: not accepted after %0d cycles, expected acceptance", nm, n);
      end
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (expq.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (expq.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", expq.size());
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      rst          = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk("reset_resp_valid", 64'(resp_valid), 64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd1);
      chk("reset_resp_rdata", 64'(resp_rdata), 64'd0);
      chk("reset_resp_err", 64'(resp_err), 64'd0);
      chk("reset_resp_write", 64'(resp_write), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 16; i++) begin
         pre_word[i] = $urandom;
         issue(1'b1, 2'd2, 1'b0, 32'(i*4), pre_word[i], "preload");
      end

      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "sw_10", 1'b1, 32'd0, 1'b0);
      issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055, "sb_11", 1'b1, 32'd0, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "lw_10", 1'b1, 32'hDEAD55EF, 1'b0, 1'b1);
      issue(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, "lb_13", 1'b1, 32'hFFFFFFDE, 1'b0);
      issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, "lbu_13", 1'b1, 32'h000000DE, 1'b0);
      issue(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, "lh_12", 1'b1, 32'hFFFFDEAD, 1'b0);
      issue(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, "lhu_12", 1'b1, 32'h0000DEAD, 1'b0);
`ifdef RAM_MISALIGN_TRAP_EN
      issue(1'b0, 2'd2, 1'b0, 32'h11, 32'd0, "lw_11_misalign", 1'b1, 32'd0, 1'b1);
`else
      issue(1'b0, 2'd2, 1'b0, 32'h11, 32'd0, "lw_11_misalign", 1'b1, 32'hDEAD55EF, 1'b0);
`endif
      issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678, "sw_oor", 1'b1, 32'd0, 1'b1);
      issue(1'b0, 2'd2, 1'b0, 32'h0, 32'd0, "lw_0_after_oor", 1'b1, pre_word[0], 1'b0);
      issue(1'b0, 2'd3, 1'b0, 32'h8, 32'd0, "ld_size_d", 1'b1, 32'd0, 1'b1);
      issue(1'b1, 2'd3, 1'b0, 32'h8, 32'hA5A5A5A5, "sd_size_d", 1'b1, 32'd0, 1'b1);
      issue(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, "lw_8_after_sd", 1'b1, pre_word[2], 1'b0);
      issue(1'b1, 2'd2, 1'b0, 32'hFFC, 32'hCAFEF00D, "sw_last", 1'b1, 32'd0, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'hFFC, 32'd0, "lw_last", 1'b1, 32'hCAFEF00D, 1'b0);
      drain();

      // Backpressure: five back-to-back loads with a three-cycle consumer stall
      fork
         begin
            for (int i = 0; i < 5; i++) issue(1'b0, 2'd2, 1'b0, 32'(i*4), 32'd0, "bp_load");
         end
         begin
            repeat (3) @(negedge clk);
            rr_force_low = 1'b1;
            for (int k = 0; k < 3; k++) begin
               if (k > 0) @(negedge clk);
               #4;
               chk("stall_req_ready", 64'(req_ready), 64'd0);
               chk("stall_resp_valid", 64'(resp_valid), 64'd1);
            end
            @(negedge clk);
            rr_force_low = 1'b0;
         end
      join
      drain();

      // Reset with two responses in flight
      rr_force_low = 1'b1;
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "rst_pending");
      issue(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, "rst_pending");
      @(negedge clk);
      chk("pre_rst_resp_valid", 64'(resp_valid), 64'd1);
      rst = 1'b0;
      expq.delete();
      #1;
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
      rr_force_low = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "lw_after_rst", 1'b1, 32'hDEAD55EF, 1'b0, 1'b1);
      drain();

      // Randomized traffic with random consumer backpressure
      rr_random = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         int          r;
         r = int'($urandom_range(9));
         if (r < 7)      a = 32'($urandom_range(63));
         else if (r < 9) a = 32'h1000 + 32'($urandom_range(255));
         else            a = $urandom;
         issue(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)), a, $urandom);
         if ($urandom_range(3) == 0) @(negedge clk);
      end
      rr_random = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_pipelined.md
# ram_pipelined

Byte-addressable, parametrised data RAM with valid/ready request and response handshakes, a configurable read-latency pipeline with backpressure, and RISC-V load/store size handling. Requests carry byte, half, word or doubleword sizes, with sign or zero extension applied on loads. The block sits behind the CPU load/store unit as the data memory and replaces the single-cycle read/write RAM.

## Interface
- DATA_WIDTH, 32: bus width in bits; only 32 or 64 are legal.
- ADDR_WIDTH, 32: byte-address width.
- DEPTH_WORDS, 1024: number of DATA_WIDTH words; must be a power of two.
- READ_LATENCY, 2: cycles from request acceptance to response; legal range 1..4.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when high with req_valid.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = B, 1 = H, 2 = W, 3 = D (D legal only when DATA_WIDTH = 64).
- req_unsigned  input  1  selects zero-extension on loads; ignored on stores.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_write  output  1  echo of req_write.
- resp_err  output  1  access fault.

## Operation
- Byte offset: addr[log2(DATA_WIDTH/8)-1:0]. Word index: next log2(DEPTH_WORDS) bits.
- Stores:
  - Byte enables are generated from size and offset.
  - Store data is shifted into the lane given by the offset.
  - Only enabled bytes are written.
  - The array is written on the acceptance edge.
- Loads:
  - The array is read synchronously on the acceptance edge.
  - The result is shifted down by the offset, masked to the access size, then sign- or zero-extended.
- Faults set resp_err = 1, suppress the array write, and force resp_rdata = 0. A fault occurs when any of these hold:
  - addr >= DEPTH_WORDS*DATA_WIDTH/8
  - req_size = D with DATA_WIDTH = 32
  - misalignment, when enabled (see Configuration)
- Every accepted request produces exactly one response, including stores and faults.
- Responses return in request order.
- Pipeline: READ_LATENCY stages, each holding valid, rdata, write and err. Stage 0 is loaded on acceptance.
- advance = !stage_last.valid || resp_ready.
- All stages shift only when advance is high.
- req_ready = advance, computed combinationally from resp_ready and stage_last.valid.
- No FSM. The per-stage valid bits are the entire control state.

## Timing
- Request accepted at edge k with no stall: resp_valid is high in the cycle after edge k+READ_LATENCY-1.
- With resp_ready held high, throughput is one request per cycle.
- Stall:
  - With resp_valid = 1 and resp_ready = 0, all stages and outputs hold and req_ready = 0.
  - Stage bubbles are not compressed while stalled.
- Load following a store to the same word, accepted the next cycle, returns the new data. The array is written before the read edge, so no bypass is needed.
- Simultaneous response consumption and request acceptance in the same cycle is legal and loses nothing.
- Reset asserted, including mid-operation:
  - Stage valids, resp_valid, resp_rdata, resp_write and resp_err go to 0 immediately.
  - In-flight responses are dropped.
  - Array contents are not reset.
  - req_ready reads 1 while in reset.
- Release: the first request can be accepted on the first rising edge after rst deasserts.

## Configuration
- RAM_MISALIGN_TRAP_EN:
  - Defined: any access whose offset is not a multiple of its size faults (resp_err = 1, no write).
  - Undefined: offset bits below the access size are cleared, and the access proceeds aligned with no error.
  - The out-of-range and illegal-D faults apply in both builds.

## Structure
- Package ram_pkg holds:
  - enum mem_size_e (B/H/W/D)
  - struct ram_stage_t (valid, rdata, write, err)
  - the function computing byte enables from size and offset
- Sub-module ram_load_align:
  - Combinational shift, mask and extend of the raw read word.
  - Shared with a future instruction-fetch RAM.
- Top level holds the array (byte-enable write loop), fault logic and the stage pipeline.

## Test plan
- Write then read, DATA_WIDTH = 32, READ_LATENCY = 2:
  - SW 0xDEADBEEF to 0x10, then SB 0x55 to 0x11.
  - LW 0x10 returns 0xDEAD55EF with resp_valid 2 cycles after acceptance.
- Load extension:
  - LB 0x13 returns 0xFFFFFFDE.
  - LBU 0x13 returns 0x000000DE.
  - LH 0x12 returns 0xFFFFDEAD.
- Backpressure:
  - Issue 5 back-to-back loads with resp_ready low for 3 cycles mid-stream.
  - All 5 responses arrive in order with none lost, and req_ready is low during the stall.
- Misalignment:
  - LW 0x11 with RAM_MISALIGN_TRAP_EN gives resp_err = 1 and rdata = 0.
  - Without the macro, it returns the word at 0x10.
- Range and size faults:
  - SW to 0x1000 with DEPTH_WORDS = 1024 gives resp_err = 1, and word 0 is unchanged.
  - req_size = D at DATA_WIDTH = 32 gives resp_err = 1.
- Reset mid-flight:
  - Assert rst with 2 responses pending: resp_valid drops to 0 immediately.
  - After release, a load returns the contents written before reset.
